// File: rtl/dmux_4way.sv
// 1-to-4 demultiplexer: routes `in` to one of a/b/c/d selected by `sel`, qualified by in_valid.
// REGISTERED=1 adds one retiming register stage with synchronous reset.
module dmux_4way #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [3:0]       sel_onehot
);

  if (REGISTERED) begin : g_reg
    logic [3:0]       hit;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic             valid_q;
    logic [3:0]       onehot_q;

    // Unknown sel or in_valid falls through to the all-zero default, so nothing is registered.
    always_comb begin
      hit = 4'b0000;
      if (in_valid) begin
        case (sel)
          2'b00:   hit = 4'b0001;
          2'b01:   hit = 4'b0010;
          2'b10:   hit = 4'b0100;
          2'b11:   hit = 4'b1000;
          default: hit = 4'b0000;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q      <= '0;
        b_q      <= '0;
        c_q      <= '0;
        d_q      <= '0;
        valid_q  <= 1'b0;
        onehot_q <= 4'b0000;
      end else begin
        a_q      <= in & {WIDTH{hit[0]}};
        b_q      <= in & {WIDTH{hit[1]}};
        c_q      <= in & {WIDTH{hit[2]}};
        d_q      <= in & {WIDTH{hit[3]}};
        valid_q  <= |hit;
        onehot_q <= hit;
      end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign c          = c_q;
    assign d          = d_q;
    assign out_valid  = valid_q;
    assign sel_onehot = onehot_q;
  end else begin : g_comb
    logic [3:0] term;
    logic       unused_clk_rst;

    assign term[0] = in_valid & ~sel[1] & ~sel[0];
    assign term[1] = in_valid & ~sel[1] &  sel[0];
    assign term[2] = in_valid &  sel[1] & ~sel[0];
    assign term[3] = in_valid &  sel[1] &  sel[0];

    assign a          = in & {WIDTH{term[0]}};
    assign b          = in & {WIDTH{term[1]}};
    assign c          = in & {WIDTH{term[2]}};
    assign d          = in & {WIDTH{term[3]}};
    assign out_valid  = in_valid;
    assign sel_onehot = term;

    // clk/rst exist only for a uniform interface in this variant.
    assign unused_clk_rst = clk ^ rst;
  end

endmodule

// File: tb/tb_dmux_4way.sv
// Self-checking bench for dmux_4way: registered WIDTH=8, registered WIDTH=1 and combinational
// WIDTH=8 instances share stimulus and are compared against a slot-routing reference model.
module tb_dmux_4way;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid;
  logic [1:0] sel;
  logic [7:0] in;

  logic [7:0] r8_a, r8_b, r8_c, r8_d;
  logic       r8_ov;
  logic [3:0] r8_oh;
  logic       r1_a, r1_b, r1_c, r1_d;
  logic       r1_ov;
  logic [3:0] r1_oh;
  logic [7:0] c8_a, c8_b, c8_c, c8_d;
  logic       c8_ov;
  logic [3:0] c8_oh;

  dmux_4way #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .sel(sel),
    .a(r8_a), .b(r8_b), .c(r8_c), .d(r8_d), .out_valid(r8_ov), .sel_onehot(r8_oh)
  );

  dmux_4way #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in[0]), .sel(sel),
    .a(r1_a), .b(r1_b), .c(r1_c), .d(r1_d), .out_valid(r1_ov), .sel_onehot(r1_oh)
  );

  dmux_4way #(.WIDTH(8), .REGISTERED(1'b0)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .sel(sel),
    .a(c8_a), .b(c8_b), .c(c8_c), .d(c8_d), .out_valid(c8_ov), .sel_onehot(c8_oh)
  );

  int checks = 0;
  int errors = 0;

  logic [36:0] prev_r8, prev_r1;
  bit          have_prev = 1'b0;

  // Reference: the word lands in slot[sel] when the transfer is live; packed {d,c,b,a,ov,onehot}.
  function automatic logic [36:0] model(input logic r, input logic v, input logic [1:0] s,
                                        input logic [7:0] x);
    logic [7:0] slot [4];
    logic [3:0] oh;
    logic       live;
    for (int i = 0; i < 4; i++) slot[i] = 8'h00;
    oh   = 4'b0000;
    live = !r && (v === 1'b1) && !$isunknown(s);
    if (live) begin
      slot[s] = x;
      oh[s]   = 1'b1;
    end
    return {slot[3], slot[2], slot[1], slot[0], live, oh};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] got_r8();
    return {r8_d, r8_c, r8_b, r8_a, r8_ov, r8_oh};
  endfunction

  function automatic logic [36:0] got_r1();
    return {7'b0, r1_d, 7'b0, r1_c, 7'b0, r1_b, 7'b0, r1_a, r1_ov, r1_oh};
  endfunction

  // Drive one cycle: combinational result checked mid-cycle, registered result after the edge.
  task automatic apply(input logic r, input logic v, input logic [1:0] s, input logic [7:0] x,
                       input string tag);
    logic [36:0] e8, e1, ec;
    rst      = r;
    in_valid = v;
    sel      = s;
    in       = x;
    #1;
    if (!$isunknown(s)) begin
      ec = model(1'b0, v, s, x);
      check({tag, "/comb8"}, {27'b0, c8_d, c8_c, c8_b, c8_a, c8_ov, c8_oh}, {27'b0, ec});
    end
    if (have_prev) begin
      check({tag, "/r8_hold"}, {27'b0, got_r8()}, {27'b0, prev_r8});
      check({tag, "/r1_hold"}, {27'b0, got_r1()}, {27'b0, prev_r1});
    end
    e8 = model(r, v, s, x);
    e1 = model(r, v, s, {7'b0, x[0]});
    @(posedge clk);
    #1;
    check({tag, "/r8"}, {27'b0, got_r8()}, {27'b0, e8});
    check({tag, "/r1"}, {27'b0, got_r1()}, {27'b0, e1});
    prev_r8   = e8;
    prev_r1   = e1;
    have_prev = 1'b1;
  endtask

  initial begin
    apply(1'b1, 1'b1, 2'b11, 8'h01, "reset0");
    apply(1'b1, 1'b1, 2'b11, 8'h01, "reset1");

    for (int x = 0; x < 2; x++) begin
      for (int s = 0; s < 4; s++) begin
        apply(1'b0, 1'b1, 2'(s), 8'(x), "truth");
      end
    end

    apply(1'b0, 1'b0, 2'b00, 8'h00, "idle");
    apply(1'b0, 1'b1, 2'b10, 8'hA5, "latency");

    apply(1'b0, 1'b1, 2'b00, 8'h11, "b2b_a");
    apply(1'b0, 1'b1, 2'b01, 8'h22, "b2b_b");
    apply(1'b0, 1'b1, 2'b10, 8'h33, "b2b_c");
    apply(1'b0, 1'b1, 2'b11, 8'h44, "b2b_d");

    apply(1'b0, 1'b0, 2'b01, 8'hFF, "invalid");
    apply(1'b0, 1'b1, 2'b10, 8'h5A, "inflight");
    apply(1'b1, 1'b1, 2'b11, 8'h77, "midrst");
    apply(1'b0, 1'b1, 2'b11, 8'h00, "zero_data");
    apply(1'b0, 1'b1, 2'bxx, 8'h3C, "xsel");
    apply(1'b1, 1'b1, 2'b01, 8'h01, "comb_rst");

    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
